// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential BCD-to-binary converter (reverse double-dabble)
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      binary,
    output logic                  err
);
    localparam int SR_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_next;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_shift;
    logic [CNT_W-1:0]   cnt;
    logic               err_l;
    logic               bad_digit;
    logic               last_shift;

    always_comb begin
        bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // Shift right, then pull each digit that reached >= 8 back by 3 (no inter-digit borrow).
    always_comb begin
        sr_shift = sr >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr_shift[BIN_W + 4*d +: 4] >= 4'd8)
                sr_shift[BIN_W + 4*d +: 4] = sr_shift[BIN_W + 4*d +: 4] - 4'd3;
        end
    end

    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            err_l  <= 1'b0;
            binary <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {bcd_in, {BIN_W{1'b0}}};
                        cnt   <= '0;
                        err_l <= bad_digit;
                    end
                end
                SHIFT: begin
                    sr  <= sr_shift;
                    cnt <= cnt + CNT_W'(1);
                    // Result registers load from the final shift so they are valid during DONE.
                    if (last_shift) begin
                        binary <= err_l ? '0 : sr_shift[BIN_W-1:0];
                        err    <= err_l;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - scoreboard bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [11:0]        bcd_in = '0;
    logic               busy, done, err;
    logic [BIN_W-1:0]   binary;

    int checks = 0;
    int failures = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .binary(binary), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] expect_of(input logic [11:0] b);
        logic [3:0] d2, d1, d0;
        d2 = b[11:8]; d1 = b[7:4]; d0 = b[3:0];
        if (d2 > 9 || d1 > 9 || d0 > 9) return {1'b1, 10'd0};
        return {1'b0, 10'(d2 * 100 + d1 * 10 + d0)};
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Behavioural model: state, shift count, expected-result queue, held outputs.
    int               ms = 0;
    int               mc = 0;
    logic [10:0]      mq[$];
    logic [BIN_W-1:0] m_bin = '0;
    logic             m_err = 1'b0;
    logic             chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            ms = 0; mc = 0; mq.delete(); m_bin = '0; m_err = 1'b0;
        end else begin
            case (ms)
                0: if (start) begin mq.push_back(expect_of(bcd_in)); mc = 0; ms = 1; end
                1: begin mc++; if (mc == BIN_W) ms = 2; end
                default: ms = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [10:0] e;
        if (chk_en) begin
            check_eq("busy", busy, ms == 1);
            check_eq("done", done, ms == 2);
            if (ms == 2) begin
                if (mq.size() == 0) check_eq("queue_empty", 0, 1);
                else begin
                    e = mq.pop_front();
                    m_err = e[10];
                    m_bin = e[9:0];
                end
            end
            check_eq("binary", binary, m_bin);
            check_eq("err", err, m_err);
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ms == 0 && mq.size() == 0) break;
        end
        if (i == 100) check_eq("timeout", 0, 1);
    endtask

    task automatic convert(input logic [11:0] b);
        @(negedge clk);
        start = 1'b1; bcd_in = b;
        @(negedge clk);
        start = 1'b0; bcd_in = $urandom;
        wait_idle();
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_binary", binary, 0);
        check_eq("rst_err", err, 0);

        // Latency of a single conversion
        @(negedge clk);
        start = 1'b1; bcd_in = 12'h255;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin start = 1'b0; bcd_in = 12'h000; end
            if (done) begin lat = i; break; end
        end
        check_eq("latency", lat, 11);
        check_eq("bin_255", binary, 255);
        wait_idle();

        convert(12'h999); check_eq("bin_999", binary, 999);
        convert(12'h000); check_eq("bin_000", binary, 0);
        convert(12'h100); check_eq("bin_100", binary, 100);
        convert(12'h1A3); check_eq("err_1a3", err, 1); check_eq("bin_1a3", binary, 0);
        convert(12'h042); check_eq("err_042", err, 0); check_eq("bin_042", binary, 42);

        // start held high while bcd_in changes every clock
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bcd_in = to_bcd($urandom_range(0, 999));
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Reset during busy cycle 5 aborts the conversion
        convert(12'h321);
        @(negedge clk);
        start = 1'b1; bcd_in = 12'h888;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check_eq("busy_c5", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_binary", binary, 0);
        check_eq("abort_err", err, 0);
        repeat (15) @(negedge clk);
        convert(12'h777); check_eq("bin_777", binary, 777);

        // Round trip: binary -> BCD -> this block
        for (int v = 0; v < 256; v++) begin
            convert(to_bcd(v));
            check_eq("roundtrip", binary, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
